// File: rtl/fp_simd_cmd_seq.sv
// Command sequencer in front of the 4-lane FP SIMD unit: queues vector commands,
// issues them one at a time with stable operands and returns results through a slot.
module fp_simd_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int VEC_W   = 88,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_opcode,
  input  logic [VEC_W-1:0] i_cmd_in1,
  input  logic [VEC_W-1:0] i_cmd_in2,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic             o_simd_en,
  output logic [2:0]       o_simd_opcode,
  output logic [VEC_W-1:0] o_simd_in1,
  output logic [VEC_W-1:0] o_simd_in2,
  input  logic             i_simd_busy,
  input  logic             i_simd_valid,
  input  logic [VEC_W-1:0] i_simd_output,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [VEC_W-1:0] o_res_data,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_res_err,
  output logic             o_idle
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 3 + 2 * VEC_W + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Command FIFO; pointers carry one extra wrap bit to tell full from empty.
  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             run_q;

  // Hold registers feeding the SIMD unit.
  logic [2:0]       hold_op;
  logic [VEC_W-1:0] hold_in1, hold_in2;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_is_load;

  logic [CNT_W-1:0] tmo_cnt, tmo_next;
  logic             cnt_clr, cnt_inc;

  // Result slot: a result is transferred in any cycle where o_res_valid and
  // i_res_ready are both high; while valid is high and ready low, data/tag/err hold.
  logic             res_valid_q;
  logic [VEC_W-1:0] res_data_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             res_err_q;
  logic             res_set, res_set_err;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // run_q keeps ready and idle low until the first edge after reset releases.
  assign o_cmd_ready = run_q && !fifo_full;
  assign push        = i_cmd_valid && o_cmd_ready;

  assign hold_is_load = (hold_op[2:1] == 2'b11);
  assign tmo_next     = tmo_cnt + 1'b1;

  assign o_simd_opcode = hold_op;
  assign o_simd_in1    = hold_in1;
  assign o_simd_in2    = hold_in2;

  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_res_tag   = res_tag_q;
  assign o_res_err   = res_err_q;

  assign o_idle = run_q && fifo_empty && (state_q == S_IDLE) && !res_valid_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {i_cmd_opcode, i_cmd_in1, i_cmd_in2, i_cmd_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    o_simd_en   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    res_set     = 1'b0;
    res_set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The slot must already be empty here, so a new issue never overlaps a handshake.
        if (!fifo_empty && !res_valid_q) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_simd_busy) begin
          o_simd_en = 1'b1;
          if (hold_is_load) begin
            state_d = S_IDLE;
          end else begin
            cnt_clr = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (i_simd_valid) begin
          res_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (tmo_next == CNT_W'(TIMEOUT)) begin
            res_set     = 1'b1;
            res_set_err = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        tmo_cnt <= '0;
      end else if (cnt_inc) begin
        tmo_cnt <= tmo_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_op  <= '0;
      hold_in1 <= '0;
      hold_in2 <= '0;
      hold_tag <= '0;
    end else if (pop) begin
      {hold_op, hold_in1, hold_in2, hold_tag} <= fifo_mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else if (res_set) begin
      res_valid_q <= 1'b1;
      res_data_q  <= res_set_err ? '0 : i_simd_output;
      res_tag_q   <= hold_tag;
      res_err_q   <= res_set_err;
    end else if (res_valid_q && i_res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_simd_cmd_seq.sv
// Bench for fp_simd_cmd_seq: directed scenarios and a randomized run scored against
// a queue model of accepted commands, SIMD latencies and expected results.
module tb_fp_simd_cmd_seq;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int VEC_W   = 88;
  localparam int TIMEOUT = 15;
  localparam int CMD_W   = 3 + 2 * VEC_W + TAG_W;
  localparam int RES_W   = VEC_W + TAG_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic [2:0]       i_cmd_opcode = '0;
  logic [VEC_W-1:0] i_cmd_in1 = '0;
  logic [VEC_W-1:0] i_cmd_in2 = '0;
  logic [TAG_W-1:0] i_cmd_tag = '0;
  logic             i_simd_busy = 1'b0;
  logic             i_simd_valid = 1'b0;
  logic [VEC_W-1:0] i_simd_output = '0;
  logic             i_res_ready = 1'b0;
  logic             o_cmd_ready, o_simd_en, o_res_valid, o_res_err, o_idle;
  logic [2:0]       o_simd_opcode;
  logic [VEC_W-1:0] o_simd_in1, o_simd_in2, o_res_data;
  logic [TAG_W-1:0] o_res_tag;

  always #5 clk = ~clk;

  fp_simd_cmd_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W), .VEC_W(VEC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_opcode(i_cmd_opcode),
    .i_cmd_in1(i_cmd_in1), .i_cmd_in2(i_cmd_in2), .i_cmd_tag(i_cmd_tag),
    .o_simd_en(o_simd_en), .o_simd_opcode(o_simd_opcode),
    .o_simd_in1(o_simd_in1), .o_simd_in2(o_simd_in2),
    .i_simd_busy(i_simd_busy), .i_simd_valid(i_simd_valid), .i_simd_output(i_simd_output),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
    .o_res_tag(o_res_tag), .o_res_err(o_res_err), .o_idle(o_idle)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_count = 0;
  int res_count = 0;
  int en_cyc = 0;
  int hs_cyc = 0;
  logic last_acc = 1'b0;

  // Stimulus knobs: 0 = low, 1 = high, 2 = random per cycle.
  int busy_mode = 0;
  int ready_mode = 1;
  int mute_pct = 0;
  bit mute_mul = 1'b0;
  bit fixed_en = 1'b0;
  logic [VEC_W-1:0] fixed_out = '0;

  // Scoreboard state.
  logic [CMD_W-1:0] acc_q[$];
  logic [RES_W-1:0] exp_q[$];
  int               due_q[$];
  bit               shown = 1'b0;
  bit               op_active = 1'b0;
  logic [CMD_W-1:0] cur_cmd = '0;

  // SIMD unit model.
  int               cd = 0;
  bit               pend_mute = 1'b0;
  logic [VEC_W-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd3:       return 3;
      3'd4, 3'd5: return 8;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [VEC_W-1:0] simd_fn(input logic [2:0] op,
                                               input logic [VEC_W-1:0] a,
                                               input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) r[l*22 +: 22] = a[l*22 +: 22] + b[l*22 +: 22] + 22'(op);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[VEC_W-1:0];
  endfunction

  task automatic clear_model();
    acc_q.delete();
    exp_q.delete();
    due_q.delete();
    cd = 0;
    op_active = 1'b0;
    shown = 1'b0;
  endtask

  // One clock cycle: drive SIMD/consumer inputs, score the cycle, advance to next negedge.
  task automatic cycle();
    logic [CMD_W-1:0] c;
    logic [RES_W-1:0] r;
    logic [2:0]       op;
    logic [TAG_W-1:0] tg;
    logic [VEC_W-1:0] a, b;
    bit               mute;
    int               lat;
    i_simd_busy  = (busy_mode == 1) || (busy_mode == 2 && $urandom_range(0, 3) == 0);
    i_res_ready  = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 0);
    i_simd_valid = 1'b0;
    i_simd_output = rand_vec();
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !pend_mute) begin
        i_simd_valid  = 1'b1;
        i_simd_output = pend_data;
      end
    end
    #1;
    last_acc = 1'b0;
    if (rst) begin
      chk("rst_cmd_ready", o_cmd_ready, 1'b0);
      chk("rst_simd_en", o_simd_en, 1'b0);
      chk("rst_simd_op", o_simd_opcode, 3'd0);
      chk("rst_simd_in1", o_simd_in1, '0);
      chk("rst_simd_in2", o_simd_in2, '0);
      chk("rst_res_valid", o_res_valid, 1'b0);
      chk("rst_res_data", o_res_data, '0);
      chk("rst_res_tag", o_res_tag, '0);
      chk("rst_res_err", o_res_err, 1'b0);
      chk("rst_idle", o_idle, 1'b0);
    end else begin
      if (o_simd_en) begin
        en_count++;
        en_cyc = cyc;
        chk("en_expected", acc_q.size() != 0, 1'b1);
        chk("en_not_busy", i_simd_busy, 1'b0);
        chk("en_slot_free", exp_q.size() == 0, 1'b1);
        if (acc_q.size() != 0) begin
          c = acc_q.pop_front();
          cur_cmd = c;
          {op, a, b, tg} = c;
          chk("issue_op", o_simd_opcode, op);
          chk("issue_in1", o_simd_in1, a);
          chk("issue_in2", o_simd_in2, b);
          if (op < 3'd6) begin
            lat  = lat_of(op);
            mute = (mute_mul && op == 3'd2) || ($urandom_range(1, 100) <= mute_pct);
            pend_data = fixed_en ? fixed_out : simd_fn(op, a, b);
            pend_mute = mute;
            cd = lat;
            if (mute) exp_q.push_back({{VEC_W{1'b0}}, tg, 1'b1});
            else      exp_q.push_back({pend_data, tg, 1'b0});
            due_q.push_back(cyc + (mute ? TIMEOUT : lat) + 1);
            op_active = 1'b1;
          end
        end
      end else if (op_active) begin
        {op, a, b, tg} = cur_cmd;
        chk("hold_op", o_simd_opcode, op);
        chk("hold_in1", o_simd_in1, a);
        chk("hold_in2", o_simd_in2, b);
      end
      if (o_res_valid) begin
        chk("res_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          r = exp_q[0];
          if (!shown) begin
            chk("res_latency", cyc, due_q[0]);
            shown = 1'b1;
          end
          chk("res_data", o_res_data, r[RES_W-1 -: VEC_W]);
          chk("res_tag", o_res_tag, r[1 +: TAG_W]);
          chk("res_err", o_res_err, r[0]);
          if (i_res_ready) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            shown = 1'b0;
            op_active = 1'b0;
            res_count++;
            hs_cyc = cyc;
          end
        end
      end
      if (i_cmd_valid && o_cmd_ready) begin
        acc_q.push_back({i_cmd_opcode, i_cmd_in1, i_cmd_in2, i_cmd_tag});
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [TAG_W-1:0] tg,
                          input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    int guard;
    guard = 0;
    i_cmd_valid  = 1'b1;
    i_cmd_opcode = op;
    i_cmd_tag    = tg;
    i_cmd_in1    = a;
    i_cmd_in2    = b;
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 500);
    chk("push_accepted", last_acc, 1'b1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((acc_q.size() != 0 || exp_q.size() != 0 || cd != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_done", acc_q.size() == 0 && exp_q.size() == 0, 1'b1);
    chk("idle_after_drain", o_idle, 1'b1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    clear_model();
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    chk("ready_at_release", o_cmd_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("ready_after_release", o_cmd_ready, 1'b1);
    chk("idle_after_release", o_idle, 1'b1);
  endtask

  initial begin
    int e0, r0, n, guard;
    logic [VEC_W-1:0] v0f;

    // Reset state.
    #2;
    apply_reset();

    // Single add with a fixed SIMD answer.
    busy_mode = 0; ready_mode = 1;
    e0 = en_count; r0 = res_count;
    v0f = {4{22'h0F0000}};
    fixed_en = 1'b1;
    fixed_out = {4{22'h100000}};
    push_cmd(3'd0, 4'd3, v0f, v0f);
    drain(100);
    fixed_en = 1'b0;
    chk("add_en_pulses", en_count - e0, 1);
    chk("add_results", res_count - r0, 1);

    // Fill the FIFO while the SIMD unit is busy; the head sits in the hold registers,
    // so DEPTH+1 commands go in before ready falls.
    busy_mode = 1;
    n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_opcode = 3'($urandom_range(0, 3));
    i_cmd_tag = '0;
    i_cmd_in1 = rand_vec();
    i_cmd_in2 = rand_vec();
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle();
      if (last_acc) begin
        n++;
        i_cmd_opcode = 3'($urandom_range(0, 3));
        i_cmd_tag = TAG_W'(n);
        i_cmd_in1 = rand_vec();
        i_cmd_in2 = rand_vec();
      end
    end
    chk("fill_accepts", n, DEPTH + 1);
    chk("fill_ready_low", o_cmd_ready, 1'b0);
    busy_mode = 0;
    guard = 0;
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 100);
    chk("held_cmd_accepted", last_acc, 1'b1);
    i_cmd_valid = 1'b0;
    drain(400);

    // Load produces no result; reduce returns one.
    e0 = en_count; r0 = res_count;
    push_cmd(3'd6, 4'd1, rand_vec(), rand_vec());
    push_cmd(3'd4, 4'd2, rand_vec(), rand_vec());
    drain(100);
    chk("load_reduce_en", en_count - e0, 2);
    chk("load_reduce_results", res_count - r0, 1);

    // Mul that never completes times out, the next command proceeds.
    r0 = res_count;
    mute_mul = 1'b1;
    push_cmd(3'd2, 4'd7, rand_vec(), rand_vec());
    push_cmd(3'd0, 4'd8, rand_vec(), rand_vec());
    drain(200);
    mute_mul = 1'b0;
    chk("timeout_results", res_count - r0, 2);

    // Consumer backpressure holds the second command.
    ready_mode = 0;
    push_cmd(3'd0, 4'd9, rand_vec(), rand_vec());
    push_cmd(3'd1, 4'd10, rand_vec(), rand_vec());
    guard = 0;
    while (!o_res_valid && guard < 100) begin
      cycle();
      guard++;
    end
    chk("bp_res_seen", o_res_valid, 1'b1);
    e0 = en_count;
    repeat (10) cycle();
    chk("bp_no_issue", en_count, e0);
    ready_mode = 1;
    guard = 0;
    while (en_count == e0 && guard < 50) begin
      cycle();
      guard++;
    end
    chk("bp_issue_gap", en_cyc - hs_cyc, 2);
    drain(200);

    // Reset during WAIT with two commands queued.
    push_cmd(3'd2, 4'd1, rand_vec(), rand_vec());
    push_cmd(3'd2, 4'd2, rand_vec(), rand_vec());
    push_cmd(3'd2, 4'd3, rand_vec(), rand_vec());
    guard = 0;
    while (!(op_active && cd > 0 && cd < 3) && guard < 50) begin
      cycle();
      guard++;
    end
    chk("mid_wait_reached", op_active, 1'b1);
    e0 = en_count; r0 = res_count;
    apply_reset();
    repeat (30) cycle();
    chk("post_rst_no_issue", en_count, e0);
    chk("post_rst_no_result", res_count, r0);
    chk("post_rst_idle", o_idle, 1'b1);

    // Randomized traffic.
    busy_mode = 2; ready_mode = 2; mute_pct = 10;
    for (int k = 0; k < 60; k++) begin
      push_cmd(3'($urandom_range(0, 7)), TAG_W'($urandom()), rand_vec(), rand_vec());
      repeat ($urandom_range(0, 2)) cycle();
    end
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
